// File: rtl/writeback_queue_pkg.sv
// rtl/writeback_queue_pkg.sv - shared widths and queue entry type for the writeback queue
package writeback_queue_pkg;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] ridx;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - producer, register-file write and bypass lookup signals of the writeback queue
interface writeback_queue_if;
    import writeback_queue_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [REG_IDX_W-1:0] in_reg;
    logic [DATA_W-1:0]    in_data;
    logic                 wr_stall;
    logic                 EnableWrite;
    logic [REG_IDX_W-1:0] write_reg;
    logic [DATA_W-1:0]    write_data;
    logic [REG_IDX_W-1:0] lk_reg1, lk_reg2, lk_reg3;
    logic                 lk_hit1, lk_hit2, lk_hit3;
    logic [DATA_W-1:0]    lk_data1, lk_data2, lk_data3;

    modport master (
        output in_valid, in_reg, in_data, wr_stall, lk_reg1, lk_reg2, lk_reg3,
        input  in_ready, EnableWrite, write_reg, write_data,
        input  lk_hit1, lk_hit2, lk_hit3, lk_data1, lk_data2, lk_data3
    );

    modport slave (
        input  in_valid, in_reg, in_data, wr_stall, lk_reg1, lk_reg2, lk_reg3,
        output in_ready, EnableWrite, write_reg, write_data,
        output lk_hit1, lk_hit2, lk_hit3, lk_data1, lk_data2, lk_data3
    );
endinterface

// File: rtl/wbq_lookup.sv
// rtl/wbq_lookup.sv - youngest-match search of the queued entries for one bypass lookup port
module wbq_lookup
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    input  logic [REG_IDX_W-1:0]       lk_reg,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (valid[idx] && (lk_reg != '0) && (entries[idx].ridx == lk_reg)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order writeback FIFO draining into the register-file write port
// Optional bypass lookups are compiled in when WBQ_BYPASS_EN is defined.
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, enq, pop, not_empty;
    wb_entry_t        head;

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != '0);
    // Gated by rst_n so the producer sees no space while reset is held.
    assign bus.in_ready    = rst_n && (count_q < CNT_W'(DEPTH));
    assign pop             = not_empty && !bus.wr_stall;
    assign bus.EnableWrite = pop;
    assign bus.write_reg   = not_empty ? head.ridx : '0;
    assign bus.write_data  = not_empty ? head.data : '0;

    assign push = bus.in_valid && bus.in_ready;
    assign enq  = push && (bus.in_reg != '0);

    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q]   = '{ridx: bus.in_reg, data: bus.in_data};
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; the valid bits and count qualify it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef WBQ_BYPASS_EN
    wbq_lookup #(.DEPTH(DEPTH)) u_lookup1 (
        .entries(mem_q), .valid(valid_q), .rd_ptr(rd_ptr_q),
        .lk_reg(bus.lk_reg1), .hit(bus.lk_hit1), .data(bus.lk_data1)
    );
    wbq_lookup #(.DEPTH(DEPTH)) u_lookup2 (
        .entries(mem_q), .valid(valid_q), .rd_ptr(rd_ptr_q),
        .lk_reg(bus.lk_reg2), .hit(bus.lk_hit2), .data(bus.lk_data2)
    );
    wbq_lookup #(.DEPTH(DEPTH)) u_lookup3 (
        .entries(mem_q), .valid(valid_q), .rd_ptr(rd_ptr_q),
        .lk_reg(bus.lk_reg3), .hit(bus.lk_hit3), .data(bus.lk_data3)
    );
`else
    logic unused_lk;
    assign unused_lk    = ^{bus.lk_reg1, bus.lk_reg2, bus.lk_reg3};
    assign bus.lk_hit1  = 1'b0;
    assign bus.lk_hit2  = 1'b0;
    assign bus.lk_hit3  = 1'b0;
    assign bus.lk_data1 = '0;
    assign bus.lk_data2 = '0;
    assign bus.lk_data3 = '0;
`endif
endmodule
